sine_wave_analyzer: RTL
=======================

Name: sine_wave_analyzer

Overview:
Receive-side counterpart to the sine/test-signal generators. Consumes a signed 16-bit sample stream (generator output or FIR filter output) and measures it. Measures period via hysteretic rising zero crossings, averaged over WINDOW periods, plus min/max/peak-to-peak amplitude. Used in hardware benches and on-chip self-test to check filter gain and frequency response per start request.

Parameters:
DATA_W, 16, sample width (signed two's complement)
WINDOW, 4, number of full periods per measurement (>=1)
CNT_W, 24, width of sample counters
HYST, 256, hysteresis magnitude; sample must go below -HYST to re-arm crossing detect
TIMEOUT, 48000, max valid samples after start before forced completion

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all state
sample_in  in  DATA_W  signed input sample
sample_valid  in  1  sample_in qualifier; only valid samples are counted
start  in  1  single-cycle measurement request
busy  out  1  high from cycle after accepted start until result_valid
result_valid  out  1  one-cycle pulse; results stable until next accepted start
period_sum  out  CNT_W  valid samples spanning WINDOW periods
peak_max  out  DATA_W  signed maximum during MEASURE
peak_min  out  DATA_W  signed minimum during MEASURE
peak_to_peak  out  DATA_W+1  unsigned peak_max - peak_min
timeout  out  1  result produced by timeout, not by WINDOW completion

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset: state IDLE; all outputs 0; counters 0; below flag 0.
- below flag: set on valid sample < -HYST; cleared on detected crossing.
- Crossing: valid sample >= 0 while below flag = 1.
- FSM IDLE: start -> ARM; clear tot_cnt, per_cnt, xing_cnt, below, timeout; busy=1 next cycle.
- FSM ARM: each valid sample increments tot_cnt. On crossing -> MEASURE; per_cnt=0; peak_max=peak_min=that sample.
- FSM MEASURE: each valid sample increments tot_cnt and per_cnt, updates peak_max/peak_min (signed compare). Crossing increments xing_cnt. When xing_cnt reaches WINDOW -> DONE; that sample is included in per_cnt and peaks.
- Timeout: if tot_cnt reaches TIMEOUT in ARM or MEASURE -> DONE with timeout=1. If never armed, period_sum and peaks read 0. Crossing and timeout on the same sample: crossing wins, timeout=0.
- FSM DONE: result_valid=1 for exactly one cycle; busy=0 same cycle; -> IDLE.
- Latency: result_valid asserts the cycle after the clock edge that registers the final sample.
- Output registers: period_sum, peaks and peak_to_peak are registered on entry to DONE.
- peak_to_peak is computed in DATA_W+1 bits, never wraps; -32768..32767 gives 65535.
- start while busy or in DONE: ignored.
- sample_valid=0: no state change; gaps do not affect counts.
- Reset mid-operation: immediate return to IDLE; no result_valid pulse.

Decomposition:
- Shared package sig_meas_pkg: state enum (IDLE, ARM, MEASURE, DONE), default DATA_W/CNT_W constants.
- One sub-module, zero_cross_detector: holds below flag and HYST compare; emits crossing strobe per valid sample.
- Counters, peak trackers and FSM stay in the top.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 immediately; busy=0; no result_valid.
- Square stream, 8 samples +1000 then 8 samples -1000, repeating, continuous valid, WINDOW=4. Start during the negative half -> one result_valid; period_sum=64; peak_max=1000; peak_min=-1000; peak_to_peak=2000; timeout=0.
- Same stream with sample_valid toggling every cycle -> identical results; result_valid ~2x later.
- Noise alternating +100/-100 (below HYST), TIMEOUT=1000 -> result_valid after 1000th valid sample; timeout=1; period_sum=0; peaks 0.
- Full-scale square ±32767/-32768 -> peak_to_peak=65535; start pulses during busy ignored (exactly one result_valid).
- Reset asserted during MEASURE -> busy=0 immediately, no pulse. New start afterwards -> correct 64-sample result.

Source files
------------

// File: rtl/sig_meas_pkg.sv
// rtl/sig_meas_pkg.sv - shared types and default widths for the signal measurement blocks
package sig_meas_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meas_state_t;

endpackage

// File: rtl/zero_cross_detector.sv
// rtl/zero_cross_detector.sv - hysteretic rising zero-crossing detector
//   clk, reset            : clock, asynchronous active-high reset
//   clear                 : drops the below flag (new measurement)
//   sample_in/sample_valid: signed sample stream and its qualifier
//   crossing              : combinational strobe, valid sample >= 0 after being below -HYST
module zero_cross_detector #(
    parameter int DATA_W = 16,
    parameter int HYST   = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     crossing
);

    localparam logic signed [DATA_W-1:0] NEG_HYST = DATA_W'(-HYST);

    logic below;

    // Non-negative means the sign bit is clear.
    assign crossing = sample_valid && below && !sample_in[DATA_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            below <= 1'b0;
        end else if (clear || crossing) begin
            below <= 1'b0;
        end else if (sample_valid && (sample_in < NEG_HYST)) begin
            below <= 1'b1;
        end
    end

endmodule

// File: rtl/sine_wave_analyzer.sv
// rtl/sine_wave_analyzer.sv - period and amplitude measurement of a signed sample stream
//   clk, reset            : clock, asynchronous active-high reset
//   sample_in/sample_valid: signed input stream and qualifier
//   start                 : single-cycle measurement request, honoured only in IDLE
//   busy, result_valid    : measurement in progress / one-cycle completion pulse
//   period_sum            : valid samples spanning WINDOW periods
//   peak_max, peak_min    : signed extremes seen while measuring
//   peak_to_peak          : unsigned peak_max - peak_min, one bit wider so it never wraps
//   timeout               : result was forced by TIMEOUT valid samples
module sine_wave_analyzer
    import sig_meas_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WINDOW  = 4,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HYST    = 256,
    parameter int TIMEOUT = 48000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     start,
    output logic                     busy,
    output logic                     result_valid,
    output logic [CNT_W-1:0]         period_sum,
    output logic signed [DATA_W-1:0] peak_max,
    output logic signed [DATA_W-1:0] peak_min,
    output logic [DATA_W:0]          peak_to_peak,
    output logic                     timeout
);

    localparam int XW = $clog2(WINDOW + 1);

    meas_state_t state, state_next;

    logic [CNT_W-1:0]         tot_cnt, per_cnt, tot_inc;
    logic [XW-1:0]            xing_cnt;
    logic signed [DATA_W-1:0] pk_max, pk_min, nxt_max, nxt_min;
    logic signed [DATA_W:0]   ext_max, ext_min;
    logic                     crossing, start_ok, hit_to, win_done;

    assign start_ok = (state == IDLE) && start;

    zero_cross_detector #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_zcd (
        .clk          (clk),
        .reset        (reset),
        .clear        (start_ok),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .crossing     (crossing)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        tot_inc    = tot_cnt + CNT_W'(1);
        // >= so a crossing that wins over the timeout sample cannot skip the limit forever.
        hit_to     = (tot_inc >= CNT_W'(TIMEOUT));
        win_done   = crossing && (xing_cnt == XW'(WINDOW - 1));
        nxt_max    = (sample_in > pk_max) ? sample_in : pk_max;
        nxt_min    = (sample_in < pk_min) ? sample_in : pk_min;
        ext_max    = {nxt_max[DATA_W-1], nxt_max};
        ext_min    = {nxt_min[DATA_W-1], nxt_min};
        case (state)
            IDLE:    if (start) state_next = ARM;
            ARM:     if (sample_valid) begin
                         if (crossing)    state_next = MEASURE;
                         else if (hit_to) state_next = DONE;
                     end
            MEASURE: if (sample_valid && (win_done || hit_to)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy         = (state == ARM) || (state == MEASURE);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tot_cnt      <= '0;
            per_cnt      <= '0;
            xing_cnt     <= '0;
            pk_max       <= '0;
            pk_min       <= '0;
            period_sum   <= '0;
            peak_max     <= '0;
            peak_min     <= '0;
            peak_to_peak <= '0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tot_cnt  <= '0;
                    per_cnt  <= '0;
                    xing_cnt <= '0;
                    timeout  <= 1'b0;
                end
                ARM: if (sample_valid) begin
                    tot_cnt <= tot_inc;
                    if (crossing) begin
                        per_cnt <= '0;
                        pk_max  <= sample_in;
                        pk_min  <= sample_in;
                    end else if (hit_to) begin
                        // Never armed: nothing meaningful was measured.
                        timeout      <= 1'b1;
                        period_sum   <= '0;
                        peak_max     <= '0;
                        peak_min     <= '0;
                        peak_to_peak <= '0;
                    end
                end
                MEASURE: if (sample_valid) begin
                    tot_cnt <= tot_inc;
                    per_cnt <= per_cnt + CNT_W'(1);
                    pk_max  <= nxt_max;
                    pk_min  <= nxt_min;
                    if (crossing) xing_cnt <= xing_cnt + XW'(1);
                    if (win_done || hit_to) begin
                        period_sum   <= per_cnt + CNT_W'(1);
                        peak_max     <= nxt_max;
                        peak_min     <= nxt_min;
                        peak_to_peak <= $unsigned(ext_max - ext_min);
                        timeout      <= !win_done;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
